port_sense_rx: RTL

PORT_SENSE_RX -- requirements
Module: port_sense_rx

---
 rtl/port_sense_rx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/port_sense_rx.sv
// Port-sense receiver: averages N = 2^AVG_LOG2 signed samples per result with valid/ready on both sides.
// Optional window min/max outputs are built only when PORT_SENSE_MINMAX_EN is defined.
module port_sense_rx #(
    parameter int DW       = 16,
    parameter int AVG_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out_avg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
`ifdef PORT_SENSE_MINMAX_EN
    ,
    output logic signed [DW-1:0] out_min,
    output logic signed [DW-1:0] out_max
`endif
);

    localparam int AW = DW + AVG_LOG2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [AVG_LOG2:0] N_CNT = {1'b1, {AVG_LOG2{1'b0}}};

    logic [1:0]            state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [AVG_LOG2:0]     cnt_q, cnt_d;
    logic signed [DW-1:0]  avg_q, avg_d;

    logic                  accept;
    logic                  first;
    logic                  last;
    logic signed [AW-1:0]  sample_ext;
    logic signed [AW-1:0]  acc_sum;
    logic [AVG_LOG2:0]     cnt_sum;

    // Arithmetic shift floors toward minus infinity, so -7/8 yields -1.
    function automatic logic signed [DW-1:0] avg_floor(input logic signed [AW-1:0] sum);
        logic signed [AW-1:0] shifted;
        shifted = sum >>> AVG_LOG2;
        return shifted[DW-1:0];
    endfunction

    assign in_ready   = (state_q != S_HOLD);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_HOLD);
    assign out_avg    = avg_q;

    assign accept     = in_valid && in_ready;
    assign first      = (state_q == S_IDLE);
    assign sample_ext = {{AVG_LOG2{in_data[DW-1]}}, in_data};
    assign acc_sum    = first ? sample_ext : acc_q + sample_ext;
    assign cnt_sum    = first ? (AVG_LOG2+1)'(1) : cnt_q + (AVG_LOG2+1)'(1);
    assign last       = accept && (cnt_sum == N_CNT);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        if (clr) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == S_HOLD) begin
            if (out_ready) begin
                state_d = S_IDLE;
            end
        end else if (accept) begin
            acc_d   = acc_sum;
            cnt_d   = cnt_sum;
            state_d = last ? S_HOLD : S_ACCUM;
            if (last) begin
                avg_d = avg_floor(acc_sum);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
        end
    end

`ifdef PORT_SENSE_MINMAX_EN
    logic signed [DW-1:0] min_q, min_d, max_q, max_d;
    logic signed [DW-1:0] omin_q, omin_d, omax_q, omax_d;
    logic signed [DW-1:0] min_nx, max_nx;

    // The first sample of a window reseeds the trackers, so clr needs no extra handling.
    assign min_nx = (first || (in_data < min_q)) ? in_data : min_q;
    assign max_nx = (first || (in_data > max_q)) ? in_data : max_q;

    always_comb begin
        min_d  = min_q;
        max_d  = max_q;
        omin_d = omin_q;
        omax_d = omax_q;
        if (!clr && accept) begin
            min_d = min_nx;
            max_d = max_nx;
            if (last) begin
                omin_d = min_nx;
                omax_d = max_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q  <= '0;
            max_q  <= '0;
            omin_q <= '0;
            omax_q <= '0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            omin_q <= omin_d;
            omax_q <= omax_d;
        end
    end

    assign out_min = omin_q;
    assign out_max = omax_q;
`endif

endmodule
